// File: rtl/ball_pkg.sv
// Shared types and constants for the pinball ball motion controller.
// Edge bit positions match the hitEdgeCode layout reported by the collision logic.
package ball_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        LOST = 2'd2
    } ball_state_e;

    localparam int EDGE_TOP    = 3;
    localparam int EDGE_BOTTOM = 2;
    localparam int EDGE_LEFT   = 1;
    localparam int EDGE_RIGHT  = 0;

    localparam int FP_SHIFT_DEFAULT = 6;

endpackage

// File: rtl/ball_motion_ctrl_if.sv
// Frame/collision inputs and sprite position outputs of the ball motion controller.
interface ball_motion_ctrl_if;

    logic               startOfFrame;
    logic               launch;
    logic               collision;
    logic [3:0]         hitEdgeCode;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;
    logic               ballLost;
    logic               moving;

    modport master (
        output startOfFrame, launch, collision, hitEdgeCode,
        input  topLeftX, topLeftY, ballLost, moving
    );

    modport slave (
        input  startOfFrame, launch, collision, hitEdgeCode,
        output topLeftX, topLeftY, ballLost, moving
    );

endinterface

// File: rtl/ball_motion_ctrl_speed_reflect_sat.sv
// Combinational per-frame speed update: edge reflection, then gravity with |ySpeed| saturation.
module speed_reflect_sat
    import ball_pkg::*;
#(
    parameter int Y_ACCEL     = 1,
    parameter int MAX_Y_SPEED = 230
) (
    input  logic [3:0]         edges_i,
    input  logic signed [31:0] x_speed_i,
    input  logic signed [31:0] y_speed_i,
    output logic signed [31:0] x_speed_o,
    output logic signed [31:0] y_speed_o
);

    localparam logic signed [31:0] ACCEL_C = 32'(Y_ACCEL);
    localparam logic signed [31:0] MAX_C   = 32'(MAX_Y_SPEED);

    logic signed [31:0] y_ref_s;
    logic signed [31:0] y_acc_s;

    // Reflect only when the hit edge opposes the current direction of travel.
    always_comb begin
        x_speed_o = x_speed_i;
        y_ref_s   = y_speed_i;
        if (edges_i[EDGE_LEFT] && (x_speed_i < 32'sd0)) begin
            x_speed_o = -x_speed_i;
        end else if (edges_i[EDGE_RIGHT] && (x_speed_i > 32'sd0)) begin
            x_speed_o = -x_speed_i;
        end else begin
            x_speed_o = x_speed_i;
        end
        if (edges_i[EDGE_TOP] && (y_speed_i < 32'sd0)) begin
            y_ref_s = -y_speed_i;
        end else if (edges_i[EDGE_BOTTOM] && (y_speed_i > 32'sd0)) begin
            y_ref_s = -y_speed_i;
        end else begin
            y_ref_s = y_speed_i;
        end
    end

    // Gravity after reflection, clamped symmetrically.
    always_comb begin
        y_acc_s = y_ref_s + ACCEL_C;
        if (y_acc_s > MAX_C) begin
            y_speed_o = MAX_C;
        end else if (y_acc_s < -MAX_C) begin
            y_speed_o = -MAX_C;
        end else begin
            y_speed_o = y_acc_s;
        end
    end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Per-frame ball motion controller: fixed-point position/velocity, edge latch and lost detection.
// Position and speed update once per startOfFrame; all outputs are registered.
module ball_motion_ctrl
    import ball_pkg::*;
#(
    parameter int INITIAL_X       = 280,
    parameter int INITIAL_Y       = 185,
    parameter int INITIAL_X_SPEED = 40,
    parameter int INITIAL_Y_SPEED = -100,
    parameter int Y_ACCEL         = 1,
    parameter int MAX_Y_SPEED     = 230,
    parameter int BOTTOM_LIMIT    = 460,
    parameter int FP_SHIFT        = FP_SHIFT_DEFAULT
) (
    input  logic              clk,
    input  logic              resetN,
    ball_motion_ctrl_if.slave bus
);

    localparam logic signed [31:0] INIT_X_FP  = 32'(INITIAL_X * (2 ** FP_SHIFT));
    localparam logic signed [31:0] INIT_Y_FP  = 32'(INITIAL_Y * (2 ** FP_SHIFT));
    localparam logic signed [31:0] INIT_XS    = 32'(INITIAL_X_SPEED);
    localparam logic signed [31:0] INIT_YS    = 32'(INITIAL_Y_SPEED);
    localparam logic signed [31:0] BOTTOM_PIX = 32'(BOTTOM_LIMIT);

    ball_state_e        state_q, state_d;
    logic signed [31:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic signed [31:0] x_speed_q, x_speed_d, y_speed_q, y_speed_d;
    logic [3:0]         edge_q, edge_d;
    logic signed [10:0] top_left_x_q, top_left_x_d, top_left_y_q, top_left_y_d;
    logic               ball_lost_q, ball_lost_d, moving_q, moving_d;

    logic [3:0]         hit_s, eff_edge_s;
    logic signed [31:0] refl_x_s, refl_y_s, next_x_s, next_y_s, next_pix_y_s;
    logic               out_of_bounds_s;

    // A hit in the frame-boundary cycle counts in this frame rather than being latched.
    assign hit_s           = bus.collision ? bus.hitEdgeCode : 4'b0000;
    assign eff_edge_s      = edge_q | hit_s;
    assign next_x_s        = pos_x_q + refl_x_s;
    assign next_y_s        = pos_y_q + refl_y_s;
    assign next_pix_y_s    = next_y_s >>> FP_SHIFT;
    assign out_of_bounds_s = (next_pix_y_s >= BOTTOM_PIX);

    speed_reflect_sat #(
        .Y_ACCEL     (Y_ACCEL),
        .MAX_Y_SPEED (MAX_Y_SPEED)
    ) u_speed (
        .edges_i   (eff_edge_s),
        .x_speed_i (x_speed_q),
        .y_speed_i (y_speed_q),
        .x_speed_o (refl_x_s),
        .y_speed_o (refl_y_s)
    );

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= IDLE;
            pos_x_q      <= INIT_X_FP;
            pos_y_q      <= INIT_Y_FP;
            x_speed_q    <= INIT_XS;
            y_speed_q    <= INIT_YS;
            edge_q       <= 4'b0000;
            top_left_x_q <= 11'(INITIAL_X);
            top_left_y_q <= 11'(INITIAL_Y);
            ball_lost_q  <= 1'b0;
            moving_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            x_speed_q    <= x_speed_d;
            y_speed_q    <= y_speed_d;
            edge_q       <= edge_d;
            top_left_x_q <= top_left_x_d;
            top_left_y_q <= top_left_y_d;
            ball_lost_q  <= ball_lost_d;
            moving_q     <= moving_d;
        end
    end

    // Next-state logic; launch is only honoured in IDLE and LOST.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.launch) state_d = MOVE;
                else            state_d = IDLE;
            end
            MOVE: begin
                if (bus.startOfFrame && out_of_bounds_s) state_d = LOST;
                else                                     state_d = MOVE;
            end
            LOST: begin
                if (bus.launch) state_d = IDLE;
                else            state_d = LOST;
            end
            default: state_d = IDLE;
        endcase
    end

    // Position/speed integration and edge latch.
    always_comb begin
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        x_speed_d = x_speed_q;
        y_speed_d = y_speed_q;
        edge_d    = edge_q;
        case (state_q)
            MOVE: begin
                if (bus.startOfFrame) begin
                    x_speed_d = refl_x_s;
                    y_speed_d = refl_y_s;
                    pos_x_d   = next_x_s;
                    pos_y_d   = next_y_s;
                    edge_d    = 4'b0000;
                end else begin
                    edge_d    = edge_q | hit_s;
                end
            end
            LOST: begin
                edge_d = 4'b0000;
                if (bus.launch) begin
                    pos_x_d   = INIT_X_FP;
                    pos_y_d   = INIT_Y_FP;
                    x_speed_d = INIT_XS;
                    y_speed_d = INIT_YS;
                end else begin
                    pos_x_d   = pos_x_q;
                    pos_y_d   = pos_y_q;
                end
            end
            default: begin
                pos_x_d   = INIT_X_FP;
                pos_y_d   = INIT_Y_FP;
                x_speed_d = INIT_XS;
                y_speed_d = INIT_YS;
                edge_d    = 4'b0000;
            end
        endcase
    end

    // Outputs follow the next state so they line up with the updated position.
    always_comb begin
        top_left_x_d = 11'(pos_x_d >>> FP_SHIFT);
        top_left_y_d = 11'(pos_y_d >>> FP_SHIFT);
        moving_d     = (state_d == MOVE);
        ball_lost_d  = (state_d == LOST);
    end

    assign bus.topLeftX = top_left_x_q;
    assign bus.topLeftY = top_left_y_q;
    assign bus.ballLost = ball_lost_q;
    assign bus.moving   = moving_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl; MAX_Y_SPEED lowered to 120 so saturation occurs before the ball drops out.
module tb_ball_motion_ctrl;

    logic clk;
    logic resetN;
    int   pass_cnt;
    int   total_cnt;

    ball_motion_ctrl_if bus ();

    ball_motion_ctrl #(.MAX_Y_SPEED(120)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_out(input string name, input int ex, input int ey,
                             input logic emov, input logic elost);
        int gx, gy;
        gx = bus.topLeftX;
        gy = bus.topLeftY;
        total_cnt++;
        if (gx !== ex || gy !== ey || bus.moving !== emov || bus.ballLost !== elost)
            $display("FAIL %s: got x=%0d y=%0d moving=%b lost=%b, want x=%0d y=%0d moving=%b lost=%b",
                     name, gx, gy, bus.moving, bus.ballLost, ex, ey, emov, elost);
        else
            pass_cnt++;
    endtask

    task automatic frame(input logic mid_en, input logic [3:0] mid_code,
                         input logic sof_en, input logic [3:0] sof_code);
        @(negedge clk); bus.collision = mid_en; bus.hitEdgeCode = mid_code;
        @(negedge clk); bus.collision = 1'b0;   bus.hitEdgeCode = 4'b0000;
        @(negedge clk); bus.startOfFrame = 1'b1; bus.collision = sof_en; bus.hitEdgeCode = sof_code;
        @(negedge clk); bus.startOfFrame = 1'b0; bus.collision = 1'b0;  bus.hitEdgeCode = 4'b0000;
    endtask

    task automatic pulse_launch(input logic with_sof);
        @(negedge clk); bus.launch = 1'b1; bus.startOfFrame = with_sof;
        @(negedge clk); bus.launch = 1'b0; bus.startOfFrame = 1'b0;
    endtask

    task automatic test_reset();
        resetN = 1'b1;
        #1 resetN = 1'b0;
        #1;
        total_cnt++;
        if (bus.topLeftX !== 11'sd280 || bus.topLeftY !== 11'sd185 || bus.moving !== 1'b0 || bus.ballLost !== 1'b0)
            $display("FAIL reset_values: got x=%0d y=%0d moving=%b lost=%b, want 280 185 0 0",
                     bus.topLeftX, bus.topLeftY, bus.moving, bus.ballLost);
        else
            pass_cnt++;
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            frame(1'b0, 4'b0000, 1'b0, 4'b0000);
            check_out("idle_no_launch", 280, 185, 1'b0, 1'b0);
        end
    endtask

    // posX 17920+40=17960 (280), ySpeed -99, posY 11840-99=11741 (183).
    task automatic test_launch();
        pulse_launch(1'b0);
        frame(1'b0, 4'b0000, 1'b0, 4'b0000);
        check_out("launch_first_frame", 280, 183, 1'b1, 1'b0);
    endtask

    task automatic test_reflect_x();
        // Right hit with xSpeed=+40 -> -40: posX 17920 (280); ys -98, posY 11643 (181).
        frame(1'b1, 4'b0001, 1'b0, 4'b0000);
        check_out("reflect_right", 280, 181, 1'b1, 1'b0);
        // Left hit with xSpeed=-40 -> +40: posX 17960 (280); ys -97, posY 11546 (180).
        frame(1'b1, 4'b0010, 1'b0, 4'b0000);
        check_out("reflect_left", 280, 180, 1'b1, 1'b0);
        // Left hit with xSpeed=+40 ignored; launch while moving ignored: posX 18000 (281); posY 11450 (178).
        pulse_launch(1'b0);
        frame(1'b1, 4'b0010, 1'b0, 4'b0000);
        check_out("left_ignored", 281, 178, 1'b1, 1'b0);
    endtask

    // Top hit in the startOfFrame cycle with ySpeed=-96 -> 96+1=97: posX 18040 (281), posY 11547 (180).
    task automatic test_same_cycle_hit();
        frame(1'b0, 4'b0000, 1'b1, 4'b1000);
        check_out("same_cycle_top", 281, 180, 1'b1, 1'b0);
        // A latched bottom bit would now flip the downward speed: expect ys 98, posX 18080 (282), posY 11645 (181).
        frame(1'b0, 4'b0000, 1'b0, 4'b0000);
        check_out("latch_empty_after_sof", 282, 181, 1'b1, 1'b0);
    endtask

    task automatic test_fall_saturate_lost();
        int   px, py, ys, sat_frames, lx, ly;
        logic lost;
        px = 18080; py = 11645; ys = 98;
        sat_frames = 0;
        lost = 1'b0;
        for (int f = 0; f < 400 && !lost; f++) begin
            ys = (ys + 1 > 120) ? 120 : ys + 1;
            if (ys == 120) sat_frames++;
            px += 40;
            py += ys;
            lost = ((py >>> 6) >= 460);
            frame(1'b0, 4'b0000, 1'b0, 4'b0000);
            check_out("free_fall", px >>> 6, py >>> 6, !lost, lost);
        end
        total_cnt++;
        if (!lost || sat_frames < 2)
            $display("FAIL fall_budget: lost=%b sat_frames=%0d, want lost=1 sat_frames>=2", lost, sat_frames);
        else
            pass_cnt++;
        lx = px >>> 6;
        ly = py >>> 6;
        for (int f = 0; f < 2; f++) begin
            frame(1'b1, 4'b0100, 1'b1, 4'b1000);
            check_out("lost_frozen", lx, ly, 1'b0, 1'b1);
        end
        pulse_launch(1'b0);
        check_out("lost_relaunch_idle", 280, 185, 1'b0, 1'b0);
        frame(1'b0, 4'b0000, 1'b0, 4'b0000);
        check_out("idle_after_lost", 280, 185, 1'b0, 1'b0);
    endtask

    task automatic test_launch_with_sof();
        pulse_launch(1'b1);
        check_out("launch_sof_no_update", 280, 185, 1'b1, 1'b0);
        frame(1'b0, 4'b0000, 1'b0, 4'b0000);
        check_out("launch_sof_then_frame", 280, 183, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_move();
        @(negedge clk); bus.collision = 1'b1; bus.hitEdgeCode = 4'b0001;
        @(negedge clk); bus.collision = 1'b0; bus.hitEdgeCode = 4'b0000;
        #2 resetN = 1'b0;
        #1;
        check_out("async_reset_mid_move", 280, 185, 1'b0, 1'b0);
        @(negedge clk); resetN = 1'b1;
        pulse_launch(1'b1);
        // Stale right bit would give xSpeed=-40 -> posX 17880 (279).
        frame(1'b0, 4'b0000, 1'b0, 4'b0000);
        check_out("no_stale_reflection", 280, 183, 1'b1, 1'b0);
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        bus.startOfFrame = 1'b0;
        bus.launch = 1'b0;
        bus.collision = 1'b0;
        bus.hitEdgeCode = 4'b0000;
        test_reset();
        test_launch();
        test_reflect_x();
        test_same_cycle_hit();
        test_fall_saturate_lost();
        test_launch_with_sof();
        test_reset_mid_move();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ball_motion_ctrl.md
Name: ball_motion_ctrl

Overview:
- Per-frame motion controller for the pinball ball sprite.
- Owns ball position and velocity in fixed point, and integrates gravity once per video frame.
- Reflects velocity on collision edges reported during the frame.
- Drives the signed topLeftX/topLeftY inputs of the ball's square/bitmap drawing object, and flags a lost ball when it drops past the bottom limit.

Parameters:
- INITIAL_X, 280: launch position X, pixels.
- INITIAL_Y, 185: launch position Y, pixels.
- INITIAL_X_SPEED, 40: launch X speed, fixed-point units per frame.
- INITIAL_Y_SPEED, -100: launch Y speed, fixed-point units per frame (negative is up).
- Y_ACCEL, 1: gravity added to Y speed each frame.
- MAX_Y_SPEED, 230: saturation bound on |ySpeed|.
- BOTTOM_LIMIT, 460: pixel Y at or beyond which the ball is lost.
- FP_SHIFT, 6: fixed-point fraction bits (multiplier 64).

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per frame
- launch  in  1  one-cycle pulse; start, or restart after loss
- collision  in  1  ball drawing pixel overlaps an obstacle this cycle
- hitEdgeCode  in  4  obstacle side hit: [3]=top [2]=bottom [1]=left [0]=right; valid only with collision
- topLeftX  out  11 signed  ball position X, pixels
- topLeftY  out  11 signed  ball position Y, pixels
- ballLost  out  1  high while in LOST
- moving  out  1  high while in MOVE

Behaviour:
- Reset:
  - State = IDLE.
  - posX_fp = INITIAL_X<<FP_SHIFT, posY_fp = INITIAL_Y<<FP_SHIFT.
  - xSpeed = INITIAL_X_SPEED, ySpeed = INITIAL_Y_SPEED.
  - Edge latch = 0, ballLost = 0, moving = 0.
  - Outputs then read 280 / 185.
- Internal widths:
  - Positions and speeds are 32-bit signed.
  - topLeftX = posX_fp >>> FP_SHIFT (arithmetic, floor), truncated to 11 bits; same rule for Y.
  - All outputs are registered.
- States:
  - IDLE: position and speeds held at initial values; edge latch cleared every cycle. launch -> MOVE.
  - MOVE:
    - Every cycle with collision=1, edge latch |= hitEdgeCode.
    - On startOfFrame, evaluate eff = latch | (collision ? hitEdgeCode : 0), so a same-cycle hit counts in this frame. Then:
      1. Left bit and xSpeed<0 -> xSpeed negated. Right bit and xSpeed>0 -> negated. Top bit and ySpeed<0 -> negated. Bottom bit and ySpeed>0 -> negated. Bits opposing the current direction are ignored.
      2. ySpeed += Y_ACCEL, then saturated to [-MAX_Y_SPEED, +MAX_Y_SPEED].
      3. pos += speed, using the post-step-2 speeds.
      4. Edge latch cleared. A collision arriving in the same cycle is consumed by eff and not re-latched.
    - The new topLeftX/Y are visible the cycle after startOfFrame (latency 1).
    - If the updated posY pixel >= BOTTOM_LIMIT -> LOST in the same update.
    - launch in MOVE is ignored.
  - LOST: position and speeds frozen; ballLost=1; collisions ignored and latch cleared. launch -> IDLE with full reload of initial position and speeds (one cycle). A second launch is needed to move.
- launch and startOfFrame in the same cycle in IDLE: go to MOVE; no position update that frame.
- resetN low in any state, mid-frame included: immediate asynchronous return to reset values.
- No X wrap: X limits come from wall collisions only.

Decomposition:
- Shared package ball_pkg holds:
  - state enum {IDLE, MOVE, LOST}
  - edge bit index constants (EDGE_TOP=3, EDGE_BOTTOM=2, EDGE_LEFT=1, EDGE_RIGHT=0)
  - FP_SHIFT default
- One natural sub-module, speed_reflect_sat: combinational. Takes eff edges plus current speeds; returns reflected and gravity-saturated speeds.
- State register, edge latch and position integrator stay in the top module.

Test Plan:
- Reset then release, no launch, 3 startOfFrame pulses -> topLeftX=280, topLeftY=185, moving=0, ballLost=0 throughout.
- launch, then one startOfFrame -> next cycle:
  - posX_fp = 17920+40 = 17960, topLeftX = 280
  - ySpeed = -99, posY_fp = 11840-99 = 11741, topLeftY = 183
  - moving = 1
- MOVE with xSpeed=-40: collision with hitEdgeCode=4'b0010 mid-frame, then startOfFrame -> xSpeed=+40. Repeat with hitEdgeCode=4'b0001 while xSpeed=+40 -> -40. Repeat with 4'b0010 while xSpeed=+40 -> unchanged.
- Collision with hitEdgeCode=4'b0100 in the same cycle as startOfFrame while ySpeed=+50 -> ySpeed = -50+1 = -49; latch empty afterwards.
- Free fall from ySpeed=225 over 10 frames -> ySpeed saturates at 230 and stays there. Once topLeftY>=460: ballLost=1, moving=0, position frozen across further frames. launch -> 280/185, IDLE.
- resetN pulsed low mid-MOVE, between frames, with a latched edge -> outputs 280/185 and latch cleared. After release, launch plus startOfFrame applies no stale reflection.
